sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single SDRAM controller between three burst requesters: p1 (program cache
//  fill, read-only), p2 (data cache fill/writeback) and p3 (video/DMA, read/write).
//  Selects one port at a time and latches its request onto the controller.
//  Routes the per-word ready/offset strobes back to the granted port only.
//  Sits between the caches/video engine and the SDRAM controller inside NeonFox_PVP.
//  from_mem is wired from the controller to all ports directly and does not pass through here.
// PARAMETERS
//  ADDR_WIDTH  24  word address width at the controller; port addresses are truncated to it
//  DATA_WIDTH  16  write data width
//  AGE_LIMIT   8   max consecutive p3 grants while p1/p2 are pending; range 1..255
// PORTS
//  clk          in   1           system clock
//  reset        in   1           asynchronous, active-low reset
//  p1_req       in   1           p1 burst request, held until final p1_ready
//  p1_address   in   ADDR_WIDTH  p1 burst base address (offset bits [1:0] = 0)
//  p1_ready     out  1           p1 word strobe
//  p1_offset    out  2           p1 word index within burst
//  p2_req       in   1           p2 burst request
//  p2_wren      in   1           p2 burst is a write
//  p2_address   in   ADDR_WIDTH  p2 burst base address
//  p2_to_mem    in   DATA_WIDTH  p2 write word for the current p2_offset
//  p2_ready     out  1           p2 word strobe
//  p2_offset    out  2           p2 word index
//  p3_req / p3_wren / p3_address / p3_to_mem / p3_ready / p3_offset   same as p2, for p3
//  mem_req      out  1           request to controller
//  mem_wren     out  1           write burst
//  mem_address  out  ADDR_WIDTH  burst base address
//  mem_to_mem   out  DATA_WIDTH  write word, muxed from the granted port
//  mem_ready    in   1           controller word strobe
//  mem_offset   in   2           controller word index
//  grant        out  2           0 = none, 1 = p1, 2 = p2, 3 = p3
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE, grant=0, mem_req=0, mem_wren=0, mem_address=0,
//    rr_last=p2, age=0. All pX_ready=0 and pX_offset=0.
//  - FSM states: IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: if any req is pending, pick a winner and register grant, mem_address and mem_wren
//    (p1 is forced to wren=0). Set mem_req=1 on the next edge and move to BUSY.
//    Latency from req to mem_req is 1 cycle.
//  - Priority: p3 wins unless (age==AGE_LIMIT and p1|p2 pending).
//    p1 and p2 share a round-robin: the one not equal to rr_last wins when both are pending.
//  - Age counter (8-bit):
//    p3 granted while p1|p2 pending -> age+1, saturating;
//    p1/p2 granted -> age=0; no p1|p2 pending -> age=0.
//  - BUSY: mem_req, mem_address, mem_wren and grant are held constant.
//    pX_ready = mem_ready & (grant==X); pX_offset = mem_offset.
//    Both are combinational, with 0-cycle latency. Ungranted ports see ready=0.
//    mem_to_mem = to_mem of the granted port; it is 0 when grant is 0 or 1.
//  - Burst end: mem_ready & mem_offset==3 in BUSY -> mem_req=0, rr_last updated if p1/p2,
//    state DONE.
//  - DONE: one dead cycle, grant=0, all reqs ignored so requesters can drop req. Then IDLE.
//    Back-to-back bursts therefore have a minimum 2-cycle gap between mem_req pulses.
//  - mem_ready while IDLE/DONE: ignored, with no ready forwarded.
//  - A requester dropping req mid-burst is ignored; the burst completes.
//  - Reset asserted mid-burst: immediate return to reset values; the partial burst is abandoned.
// TESTING
//  1. p1_req=1 at 0x000100 alone -> mem_req next cycle, mem_address=0x000100, mem_wren=0.
//     4 p1_ready pulses at offsets 0..3, grant=1; then DONE and IDLE.
//  2. p1 and p2 both request in the same IDLE cycle after reset -> p1 granted first
//     (rr_last=p2), then p2. Repeat -> grants alternate.
//  3. p2 write, p2_to_mem=0xA5A5 -> mem_wren=1, mem_to_mem=0xA5A5.
//     p1_ready and p3_ready stay 0 throughout.
//  4. p3 held continuously with p1 pending, AGE_LIMIT=8 -> exactly 8 p3 bursts, then one p1
//     burst, then p3 resumes with age=0.
//  5. reset deasserted-to-asserted during BUSY at offset 1 -> mem_req=0 and grant=0 at once.
//     After release, a new p2 request starts a fresh burst at offset 0.
//  6. mem_ready pulsed in IDLE with p1_req=0 -> no pX_ready asserted, state stays IDLE.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Three-port burst arbiter in front of the single SDRAM controller.
// p3 (video/DMA) normally wins; an age counter lets p1/p2 (round-robin pair) in.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int AGE_LIMIT  = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  p1_req,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  output logic                  p1_ready,
  output logic [1:0]            p1_offset,

  input  logic                  p2_req,
  input  logic                  p2_wren,
  input  logic [ADDR_WIDTH-1:0] p2_address,
  input  logic [DATA_WIDTH-1:0] p2_to_mem,
  output logic                  p2_ready,
  output logic [1:0]            p2_offset,

  input  logic                  p3_req,
  input  logic                  p3_wren,
  input  logic [ADDR_WIDTH-1:0] p3_address,
  input  logic [DATA_WIDTH-1:0] p3_to_mem,
  output logic                  p3_ready,
  output logic [1:0]            p3_offset,

  output logic                  mem_req,
  output logic                  mem_wren,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_to_mem,
  input  logic                  mem_ready,
  input  logic [1:0]            mem_offset,

  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'd0;
  localparam logic [1:0] GRANT_P1   = 2'd1;
  localparam logic [1:0] GRANT_P2   = 2'd2;
  localparam logic [1:0] GRANT_P3   = 2'd3;

  localparam logic RR_P1 = 1'b0;
  localparam logic RR_P2 = 1'b1;

  localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);
  localparam logic [7:0] AGE_SAT = 8'hFF;

  state_t                  state, state_next;
  logic [1:0]              grant_next;
  logic                    mem_req_next;
  logic                    mem_wren_next;
  logic [ADDR_WIDTH-1:0]   mem_address_next;
  logic                    rr_last, rr_last_next;
  logic [7:0]              age, age_next;

  logic                    low_pending;
  logic [1:0]              low_pick;
  logic [1:0]              winner;
  logic [ADDR_WIDTH-1:0]   win_address;
  logic                    win_wren;
  logic                    busy;
  logic                    burst_end;

  // p3 yields only once it has starved the cache ports for AGE_LIMIT bursts.
  always_comb begin
    low_pending = p1_req | p2_req;
    if (p1_req && p2_req) begin
      low_pick = (rr_last == RR_P2) ? GRANT_P1 : GRANT_P2;
    end else if (p1_req) begin
      low_pick = GRANT_P1;
    end else begin
      low_pick = GRANT_P2;
    end

    if (p3_req && !(low_pending && (age == AGE_MAX))) begin
      winner = GRANT_P3;
    end else if (low_pending) begin
      winner = low_pick;
    end else begin
      winner = GRANT_NONE;
    end
  end

  always_comb begin
    win_address = '0;
    win_wren    = 1'b0;
    case (winner)
      GRANT_P1: begin
        win_address = p1_address;
        win_wren    = 1'b0;
      end
      GRANT_P2: begin
        win_address = p2_address;
        win_wren    = p2_wren;
      end
      GRANT_P3: begin
        win_address = p3_address;
        win_wren    = p3_wren;
      end
      default: begin
        win_address = '0;
        win_wren    = 1'b0;
      end
    endcase
  end

  assign busy      = (state == BUSY);
  assign burst_end = busy && mem_ready && (mem_offset == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= GRANT_NONE;
      mem_req     <= 1'b0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      rr_last     <= RR_P2;
      age         <= '0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      mem_req     <= mem_req_next;
      mem_wren    <= mem_wren_next;
      mem_address <= mem_address_next;
      rr_last     <= rr_last_next;
      age         <= age_next;
    end
  end

  always_comb begin
    state_next       = state;
    grant_next       = grant;
    mem_req_next     = mem_req;
    mem_wren_next    = mem_wren;
    mem_address_next = mem_address;
    rr_last_next     = rr_last;
    age_next         = age;

    case (state)
      IDLE: begin
        if (!low_pending) begin
          age_next = '0;
        end
        if (winner != GRANT_NONE) begin
          state_next       = BUSY;
          grant_next       = winner;
          mem_req_next     = 1'b1;
          mem_address_next = win_address;
          mem_wren_next    = win_wren;
          if (winner == GRANT_P3) begin
            if (low_pending && (age != AGE_SAT)) begin
              age_next = age + 8'd1;
            end
          end else begin
            age_next = '0;
          end
        end
      end

      BUSY: begin
        if (burst_end) begin
          state_next   = DONE;
          mem_req_next = 1'b0;
          grant_next   = GRANT_NONE;
          if (grant == GRANT_P1) begin
            rr_last_next = RR_P1;
          end else if (grant == GRANT_P2) begin
            rr_last_next = RR_P2;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word strobes reach only the granted port, and only while a burst is live.
  assign p1_ready  = busy & mem_ready & (grant == GRANT_P1);
  assign p2_ready  = busy & mem_ready & (grant == GRANT_P2);
  assign p3_ready  = busy & mem_ready & (grant == GRANT_P3);
  assign p1_offset = busy ? mem_offset : 2'd0;
  assign p2_offset = busy ? mem_offset : 2'd0;
  assign p3_offset = busy ? mem_offset : 2'd0;

  always_comb begin
    mem_to_mem = '0;
    case (grant)
      GRANT_P2: mem_to_mem = p2_to_mem;
      GRANT_P3: mem_to_mem = p3_to_mem;
      default:  mem_to_mem = '0;
    endcase
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: plays the SDRAM controller side by hand
// and compares grants, strobes and burst fields against hand-computed values.
module tb_sdram_port_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          p1_req;
  logic [AW-1:0] p1_address;
  logic          p1_ready;
  logic [1:0]    p1_offset;
  logic          p2_req;
  logic          p2_wren;
  logic [AW-1:0] p2_address;
  logic [DW-1:0] p2_to_mem;
  logic          p2_ready;
  logic [1:0]    p2_offset;
  logic          p3_req;
  logic          p3_wren;
  logic [AW-1:0] p3_address;
  logic [DW-1:0] p3_to_mem;
  logic          p3_ready;
  logic [1:0]    p3_offset;
  logic          mem_req;
  logic          mem_wren;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_to_mem;
  logic          mem_ready;
  logic [1:0]    mem_offset;
  logic [1:0]    grant;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic          got;
    logic [7:0]    latency;
    logic [1:0]    g;
    logic [AW-1:0] addr;
    logic          wren;
    logic [DW-1:0] wdata;
    logic          held;
    logic [11:0]   rdy;
    logic [7:0]    offs;
    logic          post_req;
    logic [1:0]    post_grant;
  } burst_t;

  localparam logic [11:0] RDY_P1   = 12'h249;
  localparam logic [11:0] RDY_P2   = 12'h492;
  localparam logic [11:0] RDY_P3   = 12'h924;
  localparam logic [7:0]  OFFS_ALL = 8'hE4;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .AGE_LIMIT (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .p1_req     (p1_req),
    .p1_address (p1_address),
    .p1_ready   (p1_ready),
    .p1_offset  (p1_offset),
    .p2_req     (p2_req),
    .p2_wren    (p2_wren),
    .p2_address (p2_address),
    .p2_to_mem  (p2_to_mem),
    .p2_ready   (p2_ready),
    .p2_offset  (p2_offset),
    .p3_req     (p3_req),
    .p3_wren    (p3_wren),
    .p3_address (p3_address),
    .p3_to_mem  (p3_to_mem),
    .p3_ready   (p3_ready),
    .p3_offset  (p3_offset),
    .mem_req    (mem_req),
    .mem_wren   (mem_wren),
    .mem_address(mem_address),
    .mem_to_mem (mem_to_mem),
    .mem_ready  (mem_ready),
    .mem_offset (mem_offset),
    .grant      (grant)
  );

  // Controller stand-in: waits (bounded) for mem_req, then strobes offsets 0..3
  // one per cycle and records what the arbiter showed on each beat.
  task automatic drive_burst(output burst_t b);
    int n;
    b      = '0;
    b.held = 1'b1;
    n      = 0;
    while (!b.got && n < 20) begin
      @(negedge clk); #1;
      n++;
      if (mem_req === 1'b1) b.got = 1'b1;
    end
    b.latency = 8'(n);
    if (b.got) begin
      b.g     = grant;
      b.addr  = mem_address;
      b.wren  = mem_wren;
      b.wdata = mem_to_mem;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin
          @(negedge clk); #1;
        end
        mem_ready  = 1'b1;
        mem_offset = 2'(i);
        #1;
        b.rdy[i*3 +: 3] = {p3_ready, p2_ready, p1_ready};
        case (b.g)
          2'd1:    b.offs[i*2 +: 2] = p1_offset;
          2'd2:    b.offs[i*2 +: 2] = p2_offset;
          default: b.offs[i*2 +: 2] = p3_offset;
        endcase
        if (mem_req !== 1'b1 || grant !== b.g || mem_address !== b.addr || mem_wren !== b.wren)
          b.held = 1'b0;
      end
      @(negedge clk);
      mem_ready  = 1'b0;
      mem_offset = 2'd0;
      #1;
      b.post_req   = mem_req;
      b.post_grant = grant;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    p1_req = 1'b1; p1_address = 24'h123450;
    p2_req = 1'b0; p2_wren = 1'b0; p2_address = '0; p2_to_mem = '0;
    p3_req = 1'b0; p3_wren = 1'b0; p3_address = '0; p3_to_mem = '0;
    mem_ready = 1'b1; mem_offset = 2'd2;
    @(negedge clk); @(negedge clk); #1;
    vectors++; if (grant !== 2'd0) begin miscompares++; $display("[TB] FAIL reset grant: got %0d want 0", grant); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset mem_req: got %b want 0", mem_req); end
    vectors++; if (mem_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL reset mem_wren: got %b want 0", mem_wren); end
    vectors++; if (mem_address !== 24'h0) begin miscompares++; $display("[TB] FAIL reset mem_address: got %h want 000000", mem_address); end
    vectors++; if ({p3_ready, p2_ready, p1_ready} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset readys: got %b want 000", {p3_ready, p2_ready, p1_ready}); end
    vectors++; if ({p3_offset, p2_offset, p1_offset} !== 6'd0) begin miscompares++; $display("[TB] FAIL reset offsets: got %b want 000000", {p3_offset, p2_offset, p1_offset}); end
    p1_req = 1'b0; mem_ready = 1'b0; mem_offset = 2'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_p1();
    burst_t b;
    @(negedge clk);
    p1_req = 1'b1; p1_address = 24'h000100; p2_to_mem = 16'h1234;
    drive_burst(b);
    p1_req = 1'b0;
    vectors++; if (b.got !== 1'b1) begin miscompares++; $display("[TB] FAIL p1 mem_req seen: got %b want 1", b.got); end
    vectors++; if (b.latency !== 8'd1) begin miscompares++; $display("[TB] FAIL p1 latency: got %0d want 1", b.latency); end
    vectors++; if (b.g !== 2'd1) begin miscompares++; $display("[TB] FAIL p1 grant: got %0d want 1", b.g); end
    vectors++; if (b.addr !== 24'h000100) begin miscompares++; $display("[TB] FAIL p1 address: got %h want 000100", b.addr); end
    vectors++; if (b.wren !== 1'b0) begin miscompares++; $display("[TB] FAIL p1 wren: got %b want 0", b.wren); end
    vectors++; if (b.wdata !== 16'h0000) begin miscompares++; $display("[TB] FAIL p1 to_mem: got %h want 0000", b.wdata); end
    vectors++; if (b.rdy !== RDY_P1) begin miscompares++; $display("[TB] FAIL p1 ready beats: got %h want %h", b.rdy, RDY_P1); end
    vectors++; if (b.offs !== OFFS_ALL) begin miscompares++; $display("[TB] FAIL p1 offsets: got %h want %h", b.offs, OFFS_ALL); end
    vectors++; if (b.held !== 1'b1) begin miscompares++; $display("[TB] FAIL p1 held during burst: got %b want 1", b.held); end
    vectors++; if ({b.post_req, b.post_grant} !== 3'b000) begin miscompares++; $display("[TB] FAIL p1 done req/grant: got %b want 000", {b.post_req, b.post_grant}); end
    @(negedge clk); @(negedge clk); #1;
    vectors++; if ({mem_req, grant} !== 3'b000) begin miscompares++; $display("[TB] FAIL p1 idle after: got %b want 000", {mem_req, grant}); end
  endtask

  task automatic test_round_robin();
    burst_t     b;
    logic [1:0] exp_g;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    p1_req = 1'b1; p1_address = 24'h000400;
    p2_req = 1'b1; p2_wren = 1'b0; p2_address = 24'h000800;
    for (int k = 0; k < 4; k++) begin
      drive_burst(b);
      exp_g = (k % 2 == 0) ? 2'd1 : 2'd2;
      vectors++; if (b.g !== exp_g) begin miscompares++; $display("[TB] FAIL rr grant #%0d: got %0d want %0d", k, b.g, exp_g); end
      vectors++; if (b.addr !== ((exp_g == 2'd1) ? 24'h000400 : 24'h000800)) begin miscompares++; $display("[TB] FAIL rr address #%0d: got %h", k, b.addr); end
      if (k == 1) begin
        vectors++; if (b.latency !== 8'd2) begin miscompares++; $display("[TB] FAIL rr gap: got %0d want 2", b.latency); end
      end
    end
    p1_req = 1'b0; p2_req = 1'b0;
  endtask

  task automatic test_p2_write();
    burst_t b;
    @(negedge clk);
    p2_req = 1'b1; p2_wren = 1'b1; p2_address = 24'h00ABC4; p2_to_mem = 16'hA5A5;
    drive_burst(b);
    p2_req = 1'b0; p2_wren = 1'b0;
    vectors++; if (b.g !== 2'd2) begin miscompares++; $display("[TB] FAIL p2 grant: got %0d want 2", b.g); end
    vectors++; if (b.wren !== 1'b1) begin miscompares++; $display("[TB] FAIL p2 wren: got %b want 1", b.wren); end
    vectors++; if (b.addr !== 24'h00ABC4) begin miscompares++; $display("[TB] FAIL p2 address: got %h want 00abc4", b.addr); end
    vectors++; if (b.wdata !== 16'hA5A5) begin miscompares++; $display("[TB] FAIL p2 to_mem: got %h want a5a5", b.wdata); end
    vectors++; if (b.rdy !== RDY_P2) begin miscompares++; $display("[TB] FAIL p2 ready beats: got %h want %h", b.rdy, RDY_P2); end
    vectors++; if (b.offs !== OFFS_ALL) begin miscompares++; $display("[TB] FAIL p2 offsets: got %h want %h", b.offs, OFFS_ALL); end
  endtask

  task automatic test_aging();
    burst_t     b;
    logic [1:0] exp_g;
    @(negedge clk);
    p3_req = 1'b1; p3_wren = 1'b1; p3_address = 24'h300000; p3_to_mem = 16'h3C3C;
    p1_req = 1'b1; p1_address = 24'h000200;
    for (int k = 0; k < 18; k++) begin
      drive_burst(b);
      exp_g = (k == 8 || k == 17) ? 2'd1 : 2'd3;
      vectors++; if (b.g !== exp_g) begin miscompares++; $display("[TB] FAIL age grant #%0d: got %0d want %0d", k, b.g, exp_g); end
      if (k == 0) begin
        vectors++; if ({b.wren, b.wdata} !== {1'b1, 16'h3C3C}) begin miscompares++; $display("[TB] FAIL p3 wren/to_mem: got %b/%h want 1/3c3c", b.wren, b.wdata); end
        vectors++; if (b.rdy !== RDY_P3) begin miscompares++; $display("[TB] FAIL p3 ready beats: got %h want %h", b.rdy, RDY_P3); end
      end
      if (k == 8) begin
        vectors++; if ({b.wren, b.addr} !== {1'b0, 24'h000200}) begin miscompares++; $display("[TB] FAIL aged p1 wren/addr: got %b/%h want 0/000200", b.wren, b.addr); end
      end
    end
    p1_req = 1'b0; p3_req = 1'b0; p3_wren = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    burst_t b;
    int     n;
    n = 0;
    @(negedge clk);
    p2_req = 1'b1; p2_wren = 1'b0; p2_address = 24'h000040;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset wait mem_req: got %b want 1", mem_req); end
    mem_ready = 1'b1; mem_offset = 2'd0;
    @(negedge clk); #1;
    mem_offset = 2'd1; #1;
    vectors++; if (p2_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset p2_ready before: got %b want 1", p2_ready); end
    reset = 1'b0; #1;
    vectors++; if ({mem_req, grant} !== 3'b000) begin miscompares++; $display("[TB] FAIL midreset req/grant: got %b want 000", {mem_req, grant}); end
    vectors++; if (p2_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset p2_ready: got %b want 0", p2_ready); end
    vectors++; if (mem_address !== 24'h0) begin miscompares++; $display("[TB] FAIL midreset address: got %h want 000000", mem_address); end
    @(negedge clk);
    mem_ready = 1'b0; mem_offset = 2'd0; reset = 1'b1;
    drive_burst(b);
    p2_req = 1'b0;
    vectors++; if ({b.latency, b.g} !== {8'd1, 2'd2}) begin miscompares++; $display("[TB] FAIL midreset restart latency/grant: got %0d/%0d want 1/2", b.latency, b.g); end
    vectors++; if (b.offs !== OFFS_ALL) begin miscompares++; $display("[TB] FAIL midreset restart offsets: got %h want %h", b.offs, OFFS_ALL); end
    vectors++; if (b.rdy !== RDY_P2) begin miscompares++; $display("[TB] FAIL midreset restart readys: got %h want %h", b.rdy, RDY_P2); end
  endtask

  task automatic test_idle_ready();
    burst_t b;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; mem_offset = 2'(3 - i); #1;
      vectors++; if ({p3_ready, p2_ready, p1_ready, mem_req} !== 4'b0000) begin miscompares++; $display("[TB] FAIL idle strobe %0d: got %b want 0000", i, {p3_ready, p2_ready, p1_ready, mem_req}); end
      @(negedge clk);
    end
    mem_ready = 1'b0; mem_offset = 2'd0;
    p1_req = 1'b1; p1_address = 24'h000A00;
    drive_burst(b);
    p1_req = 1'b0;
    vectors++; if ({b.latency, b.g} !== {8'd1, 2'd1}) begin miscompares++; $display("[TB] FAIL idle then p1 latency/grant: got %0d/%0d want 1/1", b.latency, b.g); end
    vectors++; if (b.offs !== OFFS_ALL) begin miscompares++; $display("[TB] FAIL idle then p1 offsets: got %h want %h", b.offs, OFFS_ALL); end
  endtask

  initial begin
    test_reset();
    test_single_p1();
    test_round_robin();
    test_p2_write();
    test_aging();
    test_reset_mid_burst();
    test_idle_ready();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
